// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU/divider types, width constant and magnitude helper
package alu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Two's-complement negate when neg is set; -2^(W-1) maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] abs_w(input logic [DIV_WIDTH-1:0] v,
                                                   input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] upper;
    logic [WIDTH:0] diff;

    // upper < dsr always holds a borrow into diff[WIDTH], so that bit is the trial sign.
    always_comb begin
        upper = {rem, quo[WIDTH-1]};
        diff  = upper - {1'b0, dsr};
        if (diff[WIDTH]) begin
            rem_nxt = upper[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div32.sv
// rtl/seq_div32.sv - multi-cycle signed/unsigned restoring divider with start/done handshake
module seq_div32
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dsr_mag, dvd_raw;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic             neg_q, neg_r, dz;
    logic             sgn_dvd, sgn_dsr;

    assign sgn_dvd = is_signed & dividend[WIDTH-1];
    assign sgn_dsr = is_signed & divisor[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dsr     (dsr_mag),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? FIX : RUN;
            RUN:  if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr_mag     <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_raw <= dividend;
                        quo     <= abs_w(dividend, sgn_dvd);
                        dsr_mag <= abs_w(divisor, sgn_dsr);
                        rem     <= '0;
                        cnt     <= CW'(WIDTH);
                        neg_q   <= sgn_dvd ^ sgn_dsr;
                        neg_r   <= sgn_dvd;
                        dz      <= (divisor == '0);
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    // Divide-by-zero returns the RISC-V style all-ones quotient and raw dividend.
                    if (dz) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= abs_w(quo, neg_q);
                        remainder   <= abs_w(rem, neg_r);
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
